uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_tx_scheduler.sv | 145 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART transmit scheduler
//
// Holds the transmitter state enum, the data width and the frame length.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (PARITY state)
// between the data bits and the stop bit, growing the frame from 10 to 11 bit-times.

package uart_tx_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;
`else
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-time counter producing one tick per serial bit
//
// Ports:
//   CLK    in   rising-edge clock
//   RST_N  in   asynchronous active-low reset
//   clear  in   hold the counter at zero (used while the transmitter is idle)
//   tick   out  one-cycle pulse when the count reaches CLKS_PER_BIT-1

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // The counter wraps on the same edge the FSM leaves a state, so every state
    // is entered with the counter at zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte arbiter feeding a single UART transmitter
//
// Ports:
//   CLK         in   rising-edge clock
//   RST_N       in   asynchronous active-low reset
//   REQ         in   [NUM_REQ]   per-requester byte-pending level
//   DATA        in   [NUM_REQ*8] requester i byte at DATA[8i+7:8i]
//   GNT         out  [NUM_REQ]   one-hot pulse in the cycle the byte is accepted
//   SERIAL_OUT  out  UART line, idle high
//   BUSY        out  high whenever a frame is in progress
//   TX_DONE     out  one-cycle pulse in the last cycle of the stop bit
// Optional feature macro: UART_TX_PARITY_EN (even-parity bit before the stop bit).

module uart_tx_scheduler
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_REQ      = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [NUM_REQ*8-1:0] DATA,
    output logic [NUM_REQ-1:0]   GNT,
    output logic                 SERIAL_OUT,
    output logic                 BUSY,
    output logic                 TX_DONE
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t        state;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       tx_byte;
    logic [2:0]       bit_idx;
    logic             serial_q;

    logic             tick;
    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] next_ptr;
    logic             grant_now;
    int               idx;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clear (state == S_IDLE),
        .tick  (tick)
    );

    // Round-robin search starting at ptr; first pending requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    assign next_ptr = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    // GNT is combinational so the requester sees it in the acceptance cycle;
    // gating with RST_N keeps it low while reset is held even if REQ is high.
    assign grant_now  = (state == S_IDLE) && RST_N && found;
    assign GNT        = grant_now ? (NUM_REQ'(1) << win) : '0;
    assign BUSY       = (state != S_IDLE);
    assign TX_DONE    = (state == S_STOP) && tick;
    assign SERIAL_OUT = serial_q;

    // The line level is registered on the edge that enters each bit, so it
    // changes exactly when the FSM changes state or bit index.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            ptr      <= '0;
            tx_byte  <= '0;
            bit_idx  <= '0;
            serial_q <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    serial_q <= 1'b1;
                    bit_idx  <= '0;
                    if (grant_now) begin
                        tx_byte  <= DATA[{win, 3'b000} +: 8];
                        ptr      <= next_ptr;
                        serial_q <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        serial_q <= tx_byte[0];
                        bit_idx  <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            serial_q <= ^tx_byte;
                            state    <= S_PARITY;
`else
                            serial_q <= 1'b1;
                            state    <= S_STOP;
`endif
                        end else begin
                            serial_q <= tx_byte[bit_idx + 3'd1];
                            bit_idx  <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        serial_q <= 1'b1;
                        state    <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        serial_q <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    serial_q <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler

module tb_uart_tx_scheduler;

    localparam int CPB = 4;
    localparam int NR  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS_TB = 11;
`else
    localparam int FRAME_BITS_TB = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS_TB * CPB;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;
    logic [NR-1:0] REQ   = '0;
    logic [31:0]   DATA  = '0;
    logic [NR-1:0] GNT;
    logic          SERIAL_OUT;
    logic          BUSY;
    logic          TX_DONE;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    uart_tx_scheduler #(
        .CLKS_PER_BIT (CPB),
        .NUM_REQ      (NR)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ        (REQ),
        .DATA       (DATA),
        .GNT        (GNT),
        .SERIAL_OUT (SERIAL_OUT),
        .BUSY       (BUSY),
        .TX_DONE    (TX_DONE)
    );

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK); #1;
            if (BUSY === 1'b0) break;
        end
        total++;
        if (BUSY !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_timeout: BUSY=%b required 0", name, BUSY);
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        REQ   = 4'hF;
        DATA  = 32'h44332211;
        repeat (2) @(negedge CLK);
        #1;
        total++; if (SERIAL_OUT !== 1'b1) begin bad++; $display("FAIL rst_serial: got %b need 1", SERIAL_OUT); end
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b need 0000", GNT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b need 0", BUSY); end
        total++; if (TX_DONE !== 1'b0) begin bad++; $display("FAIL rst_txdone: got %b need 0", TX_DONE); end
        @(negedge CLK);
        REQ   = '0;
        RST_N = 1'b1;
        #1;
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rst_release_gnt: got %b need 0000", GNT); end
    endtask

    task automatic test_single_frame;
        logic [10:0] exp_line;
`ifdef UART_TX_PARITY_EN
        exp_line = 11'b11000010110;
`else
        exp_line = 11'b01000010110;
`endif
        @(negedge CLK);
        DATA[7:0] = 8'h0B;
        REQ       = 4'b0001;
        #1;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL frame_gnt: got %b need 0001", GNT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL frame_grant_busy: got %b need 0", BUSY); end
        for (int c = 1; c <= FRAME_CYC; c++) begin
            @(negedge CLK);
            if (c == 1) REQ = '0;
            #1;
            total++;
            if (SERIAL_OUT !== exp_line[(c-1)/CPB]) begin
                bad++; $display("FAIL frame_line_c%0d: got %b need %b", c, SERIAL_OUT, exp_line[(c-1)/CPB]);
            end
            total++;
            if (TX_DONE !== (c == FRAME_CYC)) begin
                bad++; $display("FAIL frame_txdone_c%0d: got %b need %b", c, TX_DONE, (c == FRAME_CYC));
            end
            total++;
            if (BUSY !== 1'b1) begin bad++; $display("FAIL frame_busy_c%0d: got %b need 1", c, BUSY); end
        end
        @(negedge CLK); #1;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL frame_end_busy: got %b need 0", BUSY); end
        total++; if (SERIAL_OUT !== 1'b1) begin bad++; $display("FAIL frame_end_line: got %b need 1", SERIAL_OUT); end
    endtask

    task automatic test_round_robin;
        int exp_order[5];
        int n;
        int last;
        exp_order = '{0, 1, 2, 3, 0};
        n = 0;
        last = -1;
        @(negedge CLK); RST_N = 1'b0;
        @(negedge CLK); RST_N = 1'b1;
        @(negedge CLK);
        DATA = 32'h44332211;
        REQ  = 4'hF;
        for (int cyc = 0; cyc < 300 && n < 5; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            #1;
            total++;
            if ((BUSY === 1'b1 && GNT !== 4'b0000) || (BUSY === 1'b0 && GNT === 4'b0000)) begin
                bad++; $display("FAIL rr_gnt_vs_busy_cyc%0d: gnt=%b busy=%b", cyc, GNT, BUSY);
            end
            if (GNT !== 4'b0000) begin
                total++;
                if (GNT !== 4'(1 << exp_order[n])) begin
                    bad++; $display("FAIL rr_order_%0d: got %b need %b", n, GNT, 4'(1 << exp_order[n]));
                end
                if (n > 0) begin
                    total++;
                    if (cyc - last != FRAME_CYC + 1) begin
                        bad++; $display("FAIL rr_gap_%0d: got %0d need %0d", n, cyc - last, FRAME_CYC + 1);
                    end
                end
                last = cyc;
                n++;
            end
        end
        total++;
        if (n != 5) begin bad++; $display("FAIL rr_grant_count: got %0d need 5", n); end
        @(negedge CLK);
        REQ = '0;
        wait_idle("rr");
    endtask

    task automatic test_reset_midframe;
        @(negedge CLK);
        DATA[7:0] = 8'h00;
        REQ       = 4'b0001;
        #1;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL mid_gnt: got %b need 0001", GNT); end
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (c == 1) REQ = '0;
        end
        #1;
        total++; if (SERIAL_OUT !== 1'b0) begin bad++; $display("FAIL mid_line_before: got %b need 0", SERIAL_OUT); end
        RST_N = 1'b0;
        #1;
        total++; if (SERIAL_OUT !== 1'b1) begin bad++; $display("FAIL mid_rst_line: got %b need 1", SERIAL_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b need 0", BUSY); end
        total++; if (TX_DONE !== 1'b0) begin bad++; $display("FAIL mid_rst_txdone: got %b need 0", TX_DONE); end
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        DATA  = 32'h00CC00AA;
        REQ   = 4'b0101;
        #1;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL mid_ptr_reset_gnt: got %b need 0001", GNT); end
        for (int c = 1; c <= FRAME_CYC + 2; c++) begin
            @(negedge CLK);
            if (c == 1) REQ = '0;
            #1;
            if (c == 1) begin
                total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mid_first_edge_busy: got %b need 1", BUSY); end
            end
            total++;
            if (TX_DONE !== (c == FRAME_CYC)) begin
                bad++; $display("FAIL mid_txdone_c%0d: got %b need %b", c, TX_DONE, (c == FRAME_CYC));
            end
        end
        wait_idle("mid");
    endtask

    task automatic test_data_change;
        logic [7:0] rx;
        rx = '0;
        @(negedge CLK);
        DATA[15:8] = 8'hA5;
        REQ        = 4'b0010;
        #1;
        total++; if (GNT !== 4'b0010) begin bad++; $display("FAIL dchg_gnt: got %b need 0010", GNT); end
        for (int c = 1; c <= FRAME_CYC; c++) begin
            @(negedge CLK);
            if (c == 1) REQ = '0;
            if (c == 2) DATA = 32'hFF5AFF5A;
            #1;
            if ((c-1)/CPB >= 1 && (c-1)/CPB <= 8 && (c-1)%CPB == 2) rx[(c-1)/CPB - 1] = SERIAL_OUT;
        end
        total++; if (rx !== 8'hA5) begin bad++; $display("FAIL dchg_byte: got %h need a5", rx); end
        wait_idle("dchg");
    endtask

    task automatic test_drop;
        @(negedge CLK);
        DATA[7:0] = 8'h3C;
        REQ       = 4'b0001;
        #1;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL drop_first_gnt: got %b need 0001", GNT); end
        for (int c = 1; c <= FRAME_CYC; c++) begin
            @(negedge CLK);
            if (c == 1) REQ = 4'b0010;
            if (c == 20) REQ = '0;
            #1;
            total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL drop_busy_gnt_c%0d: got %b need 0000", c, GNT); end
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK); #1;
            total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL drop_idle_gnt_%0d: got %b need 0000", c, GNT); end
            total++; if (SERIAL_OUT !== 1'b1) begin bad++; $display("FAIL drop_idle_line_%0d: got %b need 1", c, SERIAL_OUT); end
            total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL drop_idle_busy_%0d: got %b need 0", c, BUSY); end
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_round_robin;
        test_reset_midframe;
        test_data_change;
        test_drop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
